rr_grant_arbiter: RTL

- Round-robin arbiter sharing one resource among NUM_REQ requesters.
- Uses rotating-priority find-first-one selection: masked search from pointer, unmasked fallback.
- Registered one-hot grant; grant held until released by the owner; pointer advances past the last owner.
- Sits in front of any shared datapath (bus port, memory bank, FIFO write side) in the request-select path.

---
 rtl/rr_grant_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant that is held until its owner lets go.
// Define ARB_HOLD_TIMEOUT_EN to add a MAX_HOLD-cycle forced release that pulses timeout_o.
module rr_grant_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               release_i,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               busy,
  output logic               timeout_o
);

  if (NUM_REQ < 2 || MAX_HOLD < 1) begin : g_bad_param
    $error("rr_grant_arbiter: NUM_REQ must be >= 2 and MAX_HOLD >= 1");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   nxt_ptr, srch_ptr;
  logic [NUM_REQ-1:0] mask, masked, sel;
  logic               grant_end, hold_expired;

  function automatic logic [NUM_REQ-1:0] first_one(input logic [NUM_REQ-1:0] v);
    logic [NUM_REQ-1:0] r;
    logic               found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] encode(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] e;
    e = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) e = e | IDX_W'(i);
    end
    return e;
  endfunction

  assign nxt_ptr = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  // While a grant is active the search always starts just past the owner, so a
  // releasing owner that still requests naturally ends up with lowest priority.
  assign srch_ptr = (state_q == GRANT) ? nxt_ptr : ptr_q;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i >= int'(srch_ptr));
    end
    masked = req & mask;
    sel    = (|masked) ? first_one(masked) : first_one(req);
  end

  assign grant_end = release_i | ~req[idx_q] | hold_expired;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = sel;
          idx_d   = encode(sel);
        end
      end
      GRANT: begin
        if (grant_end) begin
          ptr_d = nxt_ptr;
          if (|sel) begin
            gnt_d = sel;
            idx_d = encode(sel);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             timeout_q;

  // hold_q counts completed cycles of the current grant; the last allowed cycle forces the end.
  assign hold_expired = (state_q == GRANT) && !release_i && req[idx_q] && (hold_q == HOLD_LAST);

  always_comb begin
    hold_d = hold_q;
    if (state_q == IDLE || grant_end) begin
      hold_d = '0;
    end else if (hold_q != HOLD_LAST) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= hold_expired;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign busy    = (state_q == GRANT);

endmodule
